i2c_master: RTL and testbench

- Single-byte I2C bus master: the upstream stage that drives SCL/SDA into the i2c_slave.
- One transaction per request: START, 7-bit address + R/W, slave ACK, one data byte (write or read), ACK/NACK, STOP.
- Sits between the register/control logic and the open-drain bus pads.
- Bit timing is derived from the system clock by a programmable divider.

---
 rtl/i2c_pkg.sv | 17 +
 rtl/i2c_tick_gen.sv | 35 +++
 rtl/i2c_master.sv | 139 +++++++++++++
 tb/tb_i2c_master.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// i2c_pkg: shared states, widths and bit-phase constants for the I2C master
package i2c_pkg;
    localparam int I2C_ADDR_W = 7;
    localparam int I2C_DATA_W = 8;
    localparam logic [1:0] Q_SDA_CHG = 2'd1;
    localparam logic [1:0] Q_SAMPLE = 2'd3;
    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_ADDR,
        S_ACK1,
        S_WR_DATA,
        S_RD_DATA,
        S_ACK2,
        S_STOP
    } i2c_mstate_t;
endpackage

// File: rtl/i2c_tick_gen.sv
// i2c_tick_gen: divides clk into quarter-bit ticks and tracks the bit phase q
module i2c_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    output logic       tick,
    output logic [1:0] q
);
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DW-1:0] r_div;
    logic [1:0]    r_q;

    // tick is suppressed while held clear so a divide-by-1 does not free-run in idle
    assign tick = ~clr & (r_div == DW'(CLK_DIV - 1));
    assign q    = r_q;

    // divider wraps on terminal count and advances the quarter counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div <= '0;
            r_q   <= '0;
        end else if (clr) begin
            r_div <= '0;
            r_q   <= '0;
        end else if (tick) begin
            r_div <= '0;
            r_q   <= r_q + 2'd1;
        end else begin
            r_div <= r_div + DW'(1);
        end
    end
endmodule

// File: rtl/i2c_master.sv
// i2c_master: single-byte I2C master running START, addr+R/W, ACK, data, ACK/NACK, STOP
module i2c_master
    import i2c_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [I2C_ADDR_W-1:0] addr,
    input  logic                  rw,
    input  logic [I2C_DATA_W-1:0] data_wr,
    input  logic                  sda_in,
    output logic                  scl,
    output logic                  sda_oe,
    output logic [I2C_DATA_W-1:0] data_rd,
    output logic                  busy,
    output logic                  done,
    output logic                  ack_err
);
    i2c_mstate_t           r_state, w_next;
    logic                  w_tick, w_clr, w_chg, w_smp, w_end, w_last, w_accept;
    logic                  w_scl, w_oe_lvl;
    logic [1:0]            w_q;
    logic [I2C_DATA_W-1:0] r_sh, r_data, r_data_rd;
    logic [2:0]            r_bit;
    logic                  r_rw, r_sample, r_sda_oe, r_done, r_ack_err;

    assign w_clr    = (r_state == S_IDLE);
    assign w_chg    = w_tick && (w_q == Q_SDA_CHG - 2'd1);
    assign w_smp    = w_tick && (w_q == Q_SAMPLE - 2'd1);
    assign w_end    = w_tick && (w_q == 2'd3);
    assign w_last   = w_end && (r_bit == 3'd7);
    assign w_accept = (r_state == S_IDLE) && en;

    i2c_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .clr (w_clr),
        .tick(w_tick),
        .q   (w_q)
    );

    // state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // next state, SCL shape and the SDA level to apply at the next q1 boundary
    always_comb begin
        w_next   = r_state;
        w_scl    = (r_state == S_IDLE) ? 1'b1 : (r_state == S_START) ? (w_q != 2'd3) : w_q[1];
        w_oe_lvl = 1'b0;
        case (r_state)
            S_IDLE:    w_next = en ? S_START : S_IDLE;
            S_START: begin
                w_oe_lvl = 1'b1;
                w_next   = w_end ? S_ADDR : S_START;
            end
            S_ADDR: begin
                w_oe_lvl = ~r_sh[7];
                w_next   = w_last ? S_ACK1 : S_ADDR;
            end
            S_ACK1:    w_next = !w_end ? S_ACK1 : r_sample ? S_STOP : r_rw ? S_RD_DATA : S_WR_DATA;
            S_WR_DATA: begin
                w_oe_lvl = ~r_sh[7];
                w_next   = w_last ? S_ACK2 : S_WR_DATA;
            end
            S_RD_DATA: w_next = w_last ? S_ACK2 : S_RD_DATA;
            S_ACK2:    w_next = w_end ? S_STOP : S_ACK2;
            S_STOP: begin
                w_oe_lvl = 1'b1;
                w_next   = w_end ? S_IDLE : S_STOP;
            end
            default:   w_next = S_IDLE;
        endcase
    end

    // SDA moves only with SCL low at q1, except the STOP release at q3 while SCL is high
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                              r_sda_oe <= 1'b0;
        else if (w_chg)                       r_sda_oe <= w_oe_lvl;
        else if (w_smp && r_state == S_STOP)  r_sda_oe <= 1'b0;
    end

    // request capture, bus sampling, byte shifting and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sh      <= '0;
            r_data    <= '0;
            r_data_rd <= '0;
            r_bit     <= '0;
            r_rw      <= 1'b0;
            r_sample  <= 1'b1;
            r_done    <= 1'b0;
            r_ack_err <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_sh      <= {addr, rw};
                r_data    <= data_wr;
                r_rw      <= rw;
                r_bit     <= '0;
                r_ack_err <= 1'b0;
            end
            if (w_smp) r_sample <= sda_in;
            if (w_end) begin
                case (r_state)
                    S_ADDR, S_WR_DATA: begin
                        r_sh  <= {r_sh[6:0], 1'b0};
                        r_bit <= r_bit + 3'd1;
                    end
                    S_RD_DATA: begin
                        r_sh  <= {r_sh[6:0], r_sample};
                        r_bit <= r_bit + 3'd1;
                        if (r_bit == 3'd7) r_data_rd <= {r_sh[6:0], r_sample};
                    end
                    S_ACK1: begin
                        if (r_sample)   r_ack_err <= 1'b1;
                        else if (!r_rw) r_sh <= r_data;
                    end
                    S_ACK2:  if (!r_rw && r_sample) r_ack_err <= 1'b1;
                    S_STOP:  r_done <= 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign scl     = w_scl;
    assign sda_oe  = r_sda_oe;
    assign data_rd = r_data_rd;
    assign busy    = (r_state != S_IDLE);
    assign done    = r_done;
    assign ack_err = r_ack_err;
endmodule

// File: tb/tb_i2c_master.sv
// tb_i2c_master: bus-level model check of two i2c_master instances (CLK_DIV 4 and 1)
module tb_i2c_master;
    localparam int K_START = 0;
    localparam int K_DRV   = 1;
    localparam int K_REL   = 2;
    localparam int K_STOP  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] en_a, rw_a, sdain_a, scl_a, oe_a, busy_a, done_a, ae_a;
    logic [6:0] addr_a [2];
    logic [7:0] dw_a   [2];
    logic [7:0] drd_a  [2];

    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic       fin;

    int          kind [2][20];
    logic        val  [2][20];
    logic        slb  [2][20];
    int          nb [2], nk [2], st [2], ldone [2];
    logic [1:0]  act, lon, rdon, pae, lae;
    logic [7:0]  rdb [2], prd [2], lrd [2];
    logic [31:0] emon [2], lmon [2];

    logic [31:0] mon [2];
    int          mcnt [2], nsta [2], nsto [2];
    logic [1:0]  pscl, psda;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar i = 0; i < 2; i++) begin : g_dut
        i2c_master #(
            .CLK_DIV(i == 0 ? 4 : 1)
        ) u_dut (
            .clk    (clk),
            .rst    (rst),
            .en     (en_a[i]),
            .addr   (addr_a[i]),
            .rw     (rw_a[i]),
            .data_wr(dw_a[i]),
            .sda_in (sdain_a[i]),
            .scl    (scl_a[i]),
            .sda_oe (oe_a[i]),
            .data_rd(drd_a[i]),
            .busy   (busy_a[i]),
            .done   (done_a[i]),
            .ack_err(ae_a[i])
        );
    end

    function automatic int dv(input int g);
        return (g == 0) ? 4 : 1;
    endfunction

    // open-drain bus: slave drives the level the model scheduled for the current bit
    always_comb begin : slave
        int ts, bs;
        sdain_a = 2'b11;
        for (int g = 0; g < 2; g++) begin
            ts = cyc - st[g];
            bs = (act[g] && ts >= 0) ? ts / (4 * dv(g)) : 99;
            sdain_a[g] = ~oe_a[g] & ((bs < nb[g]) ? slb[g][(bs < 20) ? bs : 19] : 1'b1);
        end
    end

    task automatic chk(input string nm, input int g, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s[%0d] cyc=%0d got=%0h expected=%0h", nm, g, cyc, a, e);
        end
    endtask

    // compare every output against the bit-level model on each falling edge
    always @(negedge clk) begin : compare
        int   d, t, nbt, b, q, k, kp;
        logic e_scl, e_oe, e_busy, e_done, e_ae, pv;
        logic [7:0] e_rd;
        for (int g = 0; g < 2; g++) begin
            d = dv(g);
            t = cyc - st[g];
            e_scl = 1'b1; e_oe = 1'b0; e_busy = 1'b0; e_done = 1'b0;
            e_ae = pae[g]; e_rd = prd[g];
            nbt = nb[g] * 4 * d;
            if (act[g] && t >= 0) begin
                e_ae = (nk[g] >= 0) && (t >= (nk[g] + 1) * 4 * d);
                e_rd = (rdon[g] && t >= 18 * 4 * d) ? rdb[g] : prd[g];
                if (t == 0) begin
                    mon[g] = 0; mcnt[g] = 0; nsta[g] = 0; nsto[g] = 0;
                end
                if (t < nbt) begin
                    b = t / (4 * d);
                    q = (t % (4 * d)) / d;
                    k = kind[g][b];
                    kp = (b == 0) ? K_REL : kind[g][b-1];
                    pv = (b == 0) ? 1'b0 : (kp == K_START) ? 1'b1 : (kp == K_DRV) ? ~val[g][b-1] : 1'b0;
                    e_busy = 1'b1;
                    e_scl = (k == K_START) ? (q != 3) : (q >= 2);
                    e_oe = (k == K_START) ? (q >= 1) :
                           (k == K_STOP)  ? (q == 1 || q == 2) :
                           (k == K_DRV)   ? ((q >= 1) ? ~val[g][b] : pv) :
                                            ((q >= 1) ? 1'b0 : pv);
                end else if (t == nbt) begin
                    e_done = 1'b1;
                end
            end
            if (scl_a[g] && !pscl[g]) begin
                mon[g] = {mon[g][30:0], sdain_a[g]};
                mcnt[g]++;
            end
            if (scl_a[g] && pscl[g] && sdain_a[g] != psda[g]) begin
                if (!sdain_a[g]) nsta[g]++;
                else             nsto[g]++;
            end
            pscl[g] = scl_a[g];
            psda[g] = sdain_a[g];
            chk("scl", g, 32'(scl_a[g]), 32'(e_scl));
            chk("sda_oe", g, 32'(oe_a[g]), 32'(e_oe));
            chk("busy", g, 32'(busy_a[g]), 32'(e_busy));
            chk("done", g, 32'(done_a[g]), 32'(e_done));
            chk("ack_err", g, 32'(ae_a[g]), 32'(e_ae));
            chk("data_rd", g, 32'(drd_a[g]), 32'(e_rd));
            if (act[g] && t == nbt) begin
                chk("bus_bits", g, mon[g], emon[g]);
                chk("scl_rises", g, 32'(mcnt[g]), 32'(nb[g] - 1));
                chk("start_cond", g, 32'(nsta[g]), 32'd1);
                chk("stop_cond", g, 32'(nsto[g]), 32'd1);
                if (lon[g]) begin
                    chk("lit_bits", g, mon[g], lmon[g]);
                    chk("lit_ack_err", g, 32'(ae_a[g]), 32'(lae[g]));
                    chk("lit_data_rd", g, 32'(drd_a[g]), 32'(lrd[g]));
                end
            end
            if (done_a[g] && act[g] && lon[g]) chk("lit_done", g, t, ldone[g]);
        end
        if (fin) begin
            $display("Result: errors=%0d of %0d checks", errors, checks);
            $finish;
        end
    end

    task automatic build(input int g, input logic [6:0] a, input logic r, input logic [7:0] w,
                         input logic k1, input logic k2, input logic [7:0] rb);
        logic [7:0] ar;
        logic       bit_v;
        ar = {a, r};
        for (int i = 0; i < 20; i++) begin
            kind[g][i] = K_REL; val[g][i] = 1'b0; slb[g][i] = 1'b1;
        end
        kind[g][0] = K_START;
        for (int i = 0; i < 8; i++) begin
            kind[g][1+i] = K_DRV; val[g][1+i] = ar[7-i];
        end
        slb[g][9] = ~k1;
        nk[g] = k1 ? -1 : 9;
        rdon[g] = 1'b0;
        rdb[g] = rb;
        if (!k1) begin
            kind[g][10] = K_STOP; nb[g] = 11;
        end else begin
            for (int i = 0; i < 8; i++) begin
                if (r) slb[g][10+i] = rb[7-i];
                else begin
                    kind[g][10+i] = K_DRV; val[g][10+i] = w[7-i];
                end
            end
            if (!r) begin
                slb[g][18] = ~k2;
                if (!k2) nk[g] = 18;
            end
            rdon[g] = r;
            kind[g][19] = K_STOP; nb[g] = 20;
        end
        emon[g] = 0;
        for (int i = 1; i < nb[g]; i++) begin
            bit_v = (kind[g][i] == K_DRV) ? val[g][i] : (kind[g][i] == K_STOP) ? 1'b0 : slb[g][i];
            emon[g] = {emon[g][30:0], bit_v};
        end
    endtask

    task automatic go(input int g, input logic [6:0] a, input logic r, input logic [7:0] w,
                      input logic k1, input logic k2, input logic [7:0] rb);
        @(posedge clk); #1;
        if (act[g]) begin
            pae[g] = (nk[g] >= 0);
            if (rdon[g]) prd[g] = rdb[g];
        end
        build(g, a, r, w, k1, k2, rb);
        st[g] = cyc + 1;
        act[g] = 1'b1;
        en_a[g] = 1'b1; addr_a[g] = a; rw_a[g] = r; dw_a[g] = w;
        @(posedge clk); #1;
        en_a[g] = 1'b0;
        addr_a[g] = 7'($urandom); rw_a[g] = 1'($urandom); dw_a[g] = 8'($urandom);
    endtask

    task automatic run(input int g, input logic [6:0] a, input logic r, input logic [7:0] w,
                       input logic k1, input logic k2, input logic [7:0] rb);
        go(g, a, r, w, k1, k2, rb);
        repeat (nb[g] * 4 * dv(g) + 4) @(posedge clk);
        #1 lon[g] = 1'b0;
    endtask

    task automatic lit(input int g, input logic [31:0] bits, input int dn, input logic ae, input logic [7:0] rd);
        lon[g] = 1'b1; lmon[g] = bits; ldone[g] = dn; lae[g] = ae; lrd[g] = rd;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        act = '0; lon = '0; pae = '0;
        prd[0] = '0; prd[1] = '0;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    initial begin
        fin = 1'b0;
        en_a = '0; rw_a = '0; act = '0; lon = '0; pae = '0; rdon = '0; lae = '0;
        pscl = '1; psda = '1;
        for (int g = 0; g < 2; g++) begin
            addr_a[g] = '0; dw_a[g] = '0; prd[g] = '0; rdb[g] = '0; lrd[g] = '0;
            nb[g] = 0; nk[g] = -1; st[g] = 0; ldone[g] = 0; emon[g] = '0; lmon[g] = '0;
            mon[g] = '0; mcnt[g] = 0; nsta[g] = 0; nsto[g] = 0;
            for (int i = 0; i < 20; i++) begin
                kind[g][i] = K_REL; val[g][i] = 1'b0; slb[g][i] = 1'b1;
            end
        end
        do_reset(3);
        repeat (3) @(posedge clk);
        lit(0, {13'd0, 8'h74, 1'b0, 8'hC5, 1'b0, 1'b0}, 320, 1'b0, 8'h00);
        run(0, 7'h3A, 1'b0, 8'hC5, 1'b1, 1'b1, 8'h00);
        lit(0, {22'd0, 8'hA0, 1'b1, 1'b0}, 176, 1'b1, 8'h00);
        run(0, 7'h50, 1'b0, 8'h5A, 1'b0, 1'b0, 8'h00);
        lit(0, {13'd0, 8'h75, 1'b0, 8'hA5, 1'b1, 1'b0}, 320, 1'b0, 8'hA5);
        run(0, 7'h3A, 1'b1, 8'h00, 1'b1, 1'b1, 8'hA5);
        lit(0, {13'd0, 8'h42, 1'b0, 8'h3C, 1'b0, 1'b0}, 320, 1'b0, 8'hA5);
        go(0, 7'h21, 1'b0, 8'h3C, 1'b1, 1'b1, 8'h00);
        repeat (49) @(posedge clk);
        #1 en_a[0] = 1'b1; addr_a[0] = 7'h7F; rw_a[0] = 1'b1; dw_a[0] = 8'h00;
        @(posedge clk);
        #1 en_a[0] = 1'b0;
        repeat (320 - 50 + 4) @(posedge clk);
        #1 lon[0] = 1'b0;
        go(0, 7'h6C, 1'b0, 8'h96, 1'b1, 1'b1, 8'h00);
        repeat (13 * 16 + 6) @(posedge clk);
        #1 do_reset(2);
        repeat (3) @(posedge clk);
        run(0, 7'h13, 1'b0, 8'hE7, 1'b1, 1'b1, 8'h00);
        lit(1, {13'd0, 8'h56, 1'b0, 8'hFF, 1'b0, 1'b0}, 80, 1'b0, 8'h00);
        run(1, 7'h2B, 1'b0, 8'hFF, 1'b1, 1'b1, 8'h00);
        for (int n = 0; n < 16; n++) begin
            run(n % 2, 7'($urandom), 1'($urandom), 8'($urandom),
                $urandom_range(0, 3) != 0, 1'($urandom), 8'($urandom));
        end
        @(posedge clk);
        #1 fin = 1'b1;
        repeat (4) @(posedge clk);
        $display("FAIL summary_not_reached got=0 expected=1");
        $fatal(1);
    end
endmodule
